// File: rtl/tt_um_ternary_seq_ctrl.sv
// Start/done, valid/ready sequencer for the ternary weight-load / matrix-vector-multiply datapath.
// Optional feature macro: TERNARY_SEQ_KEEP_WEIGHTS_EN (skip the weight load when resident weights are valid).
module tt_um_ternary_seq_ctrl #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int BUS_W       = 16,
    parameter int PIPE_LAT    = 1,
    parameter int LOAD_BEATS  = (2 * MAX_IN_LEN * MAX_OUT_LEN) / BUS_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           skip_load,
    input  logic [7:0]                     vec_count,
    input  logic                           abort,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           load_en,
    output logic [3:0]                     load_col,
    output logic                           vec_cap,
    output logic                           mult_en,
    output logic [$clog2(MAX_OUT_LEN)-1:0] mult_row,
    output logic                           out_valid,
    output logic [$clog2(MAX_OUT_LEN)-1:0] out_row,
    output logic                           busy,
    output logic                           done
);

    localparam int ROW_W   = $clog2(MAX_OUT_LEN);
    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [3:0]         LAST_COL   = 4'(LOAD_BEATS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(MAX_OUT_LEN - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

`ifdef TERNARY_SEQ_KEEP_WEIGHTS_EN
    localparam bit KEEP_WEIGHTS = 1'b1;
`else
    localparam bit KEEP_WEIGHTS = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    logic [3:0]           col;
    logic [ROW_W-1:0]     row;
    logic [7:0]           vec_left;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 weights_ok;

    logic                 accept;
    logic                 abort_now;
    logic                 skip_taken;

    logic [PIPE_LAT-1:0]            ov_pipe;
    logic [PIPE_LAT-1:0][ROW_W-1:0] row_pipe;

    assign abort_now  = abort && (state != S_IDLE);
    assign skip_taken = KEEP_WEIGHTS && skip_load && weights_ok;

    assign load_col = col;
    assign mult_row = row;
    assign out_valid = ov_pipe[PIPE_LAT-1];
    assign out_row   = row_pipe[PIPE_LAT-1];

    // Handshake strobes are combinational so a beat is written in the cycle it is accepted;
    // abort suppresses them so an aborted cycle never consumes a beat.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        in_ready = 1'b0;
        if (!abort) begin
            unique case (state)
                S_LOAD:  in_ready = 1'b1;
                S_MULT:  in_ready = (row == '0);
                default: in_ready = 1'b0;
            endcase
        end
        accept  = in_valid && in_ready;
        load_en = (state == S_LOAD) && accept;
        vec_cap = (state == S_MULT) && accept;
        mult_en = (state == S_MULT) && !abort && ((row != '0) || in_valid);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            vec_left   <= '0;
            drain_cnt  <= '0;
            weights_ok <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_now) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                col       <= '0;
                row       <= '0;
                vec_left  <= '0;
                drain_cnt <= '0;
                if (state == S_LOAD) begin
                    weights_ok <= 1'b0;
                end
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            vec_left <= vec_count;
                            busy     <= 1'b1;
                            if (skip_taken) begin
                                state <= (vec_count == 8'd0) ? S_DRAIN : S_MULT;
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (accept) begin
                            if (col == LAST_COL) begin
                                col        <= '0;
                                weights_ok <= 1'b1;
                                state      <= (vec_left == 8'd0) ? S_DRAIN : S_MULT;
                            end else begin
                                col <= col + 4'd1;
                            end
                        end
                    end
                    S_MULT: begin
                        if (mult_en) begin
                            if (row == LAST_ROW) begin
                                row      <= '0;
                                vec_left <= vec_left - 8'd1;
                                if (vec_left == 8'd1) begin
                                    state <= S_DRAIN;
                                end
                            end else begin
                                row <= row + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // Hold until the last multiplier result has left the output pipeline.
                        if (drain_cnt == DRAIN_LAST) begin
                            drain_cnt <= '0;
                            state     <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Result-valid pipeline mirrors the multiplier latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this shift register is reset (unlike a data RAM) because out_valid must read 0.
            ov_pipe  <= '0;
            row_pipe <= '0;
        end else if (abort_now) begin
            ov_pipe  <= '0;
            row_pipe <= '0;
        end else begin
            ov_pipe[0]  <= mult_en;
            row_pipe[0] <= row;
            for (int i = 1; i < PIPE_LAT; i++) begin
                ov_pipe[i]  <= ov_pipe[i-1];
                row_pipe[i] <= row_pipe[i-1];
            end
        end
    end

endmodule
